// File: rtl/instr_fetch_unit.sv
// MIPS fetch stage with IF/ID register: PC, imem req/ack handshake, one-entry
// stall buffer, flush/redirect, and field slicing of the registered instruction.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic [5:0]  id_opcode,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [4:0]  id_shamt,
    output logic [5:0]  id_funct,
    output logic [15:0] id_imm16
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        buf_valid;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc4;
    logic        accept;

    assign pc4       = pc + 32'd4;
    // Acks outside FETCH (IDLE, HOLD, reset) are ignored.
    assign accept    = (state == FETCH) && imem_ack;
    assign imem_req  = rst && (state == FETCH);
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            buf_valid <= 1'b0;
        end else if (flush) begin
            state     <= FETCH;
            pc        <= redirect_pc;
            buf_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (imem_ack) begin
                        pc <= pc4;
                        if (stall) begin
                            buf_valid <= 1'b1;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        buf_valid <= 1'b0;
                        state     <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !flush && accept && stall) begin
            buf_instr <= imem_rdata;
            buf_pc4   <= pc4;
        end
    end

    // IF/ID register: stall freezes it, a non-delivering cycle inserts a bubble.
    always_ff @(posedge clk) begin
        if (!rst) begin
            id_valid <= 1'b0;
            id_instr <= 32'd0;
            id_pc4   <= 32'd0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (!stall) begin
            if (accept) begin
                id_valid <= 1'b1;
                id_instr <= imem_rdata;
                id_pc4   <= pc4;
            end else if ((state == HOLD) && buf_valid) begin
                id_valid <= 1'b1;
                id_instr <= buf_instr;
                id_pc4   <= buf_pc4;
            end else begin
                id_valid <= 1'b0;
            end
        end
    end

    assign id_opcode = id_instr[31:26];
    assign id_rs     = id_instr[25:21];
    assign id_rt     = id_instr[20:16];
    assign id_rd     = id_instr[15:11];
    assign id_shamt  = id_instr[10:6];
    assign id_funct  = id_instr[5:0];
    assign id_imm16  = id_instr[15:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: per-cycle comparison against a transaction-level
// model, plus directed literal expectations and a wrap-around RESET_PC instance.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        id_valid;
    logic [31:0] id_instr, id_pc4;
    logic [5:0]  id_opcode, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [15:0] id_imm16;

    logic        rst2 = 1'b0;
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        imem_ack2 = 1'b0;
    logic [31:0] imem_rdata2 = 32'd0;
    logic        id_valid2;
    logic [31:0] id_instr2, id_pc4_2;
    logic [5:0]  id_opcode2, id_funct2;
    logic [4:0]  id_rs2, id_rt2, id_rd2, id_shamt2;
    logic [15:0] id_imm16_2;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .flush(flush),
        .redirect_pc(redirect_pc), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc4(id_pc4), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_shamt(id_shamt), .id_funct(id_funct), .id_imm16(id_imm16)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst2), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .stall(1'b0), .flush(1'b0),
        .redirect_pc(32'd0), .id_valid(id_valid2), .id_instr(id_instr2),
        .id_pc4(id_pc4_2), .id_opcode(id_opcode2), .id_rs(id_rs2), .id_rt(id_rt2),
        .id_rd(id_rd2), .id_shamt(id_shamt2), .id_funct(id_funct2), .id_imm16(id_imm16_2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: "started" after the first post-reset cycle, "parked" while a
    // fetched word waits for decode; memory traffic only when started and not parked.
    bit          m_started, m_parked;
    logic [31:0] m_pc, m_buf_instr, m_buf_pc4;
    bit          m_idv;
    logic [31:0] m_instr, m_pc4;

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            m_started = 0; m_parked = 0; m_pc = 32'd0;
            m_idv = 0; m_instr = 32'd0; m_pc4 = 32'd0;
        end else if (flush) begin
            m_started = 1; m_parked = 0; m_pc = redirect_pc; m_idv = 0;
        end else if (!m_started) begin
            m_started = 1;
        end else if (m_parked) begin
            if (!stall) begin
                m_parked = 0; m_idv = 1; m_instr = m_buf_instr; m_pc4 = m_buf_pc4;
            end
        end else if (imem_ack) begin
            if (stall) begin
                m_parked = 1; m_buf_instr = imem_rdata; m_buf_pc4 = m_pc + 32'd4;
            end else begin
                m_idv = 1; m_instr = imem_rdata; m_pc4 = m_pc + 32'd4;
            end
            m_pc = m_pc + 32'd4;
        end else if (!stall) begin
            m_idv = 0;
        end
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            check("req",    {31'd0, imem_req}, {31'd0, rst && m_started && !m_parked});
            check("addr",   imem_addr, m_pc);
            check("valid",  {31'd0, id_valid}, {31'd0, m_idv});
            check("instr",  id_instr, m_instr);
            check("pc4",    id_pc4, m_pc4);
            check("opcode", {26'd0, id_opcode}, {26'd0, m_instr[31:26]});
            check("rs",     {27'd0, id_rs}, {27'd0, m_instr[25:21]});
            check("rt",     {27'd0, id_rt}, {27'd0, m_instr[20:16]});
            check("rd",     {27'd0, id_rd}, {27'd0, m_instr[15:11]});
            check("shamt",  {27'd0, id_shamt}, {27'd0, m_instr[10:6]});
            check("funct",  {26'd0, id_funct}, {26'd0, m_instr[5:0]});
            check("imm16",  {16'd0, id_imm16}, {16'd0, m_instr[15:0]});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset held for two edges
        tick(); tick();
        check("t1 req", {31'd0, imem_req}, 32'd0);
        check("t1 valid", {31'd0, id_valid}, 32'd0);
        check("t1 addr", imem_addr, 32'd0);
        rst = 1'b1;
        tick();
        check("t1 req after release", {31'd0, imem_req}, 32'd1);
        check("t1 addr after release", imem_addr, 32'd0);

        // 2: zero-wait acks
        imem_ack = 1'b1; imem_rdata = 32'h2008_FFFF;
        tick();
        check("t2 valid", {31'd0, id_valid}, 32'd1);
        check("t2 opcode", {26'd0, id_opcode}, 32'h08);
        check("t2 rt", {27'd0, id_rt}, 32'd8);
        check("t2 imm16", {16'd0, id_imm16}, 32'hFFFF);
        check("t2 pc4", id_pc4, 32'd4);
        check("t2 addr4", imem_addr, 32'd4);
        imem_rdata = 32'h0000_0020;
        tick();
        check("t2 addr8", imem_addr, 32'd8);
        imem_rdata = 32'h0000_0022;
        tick();
        check("t2 addr12", imem_addr, 32'd12);
        check("t2 pc4 at 12", id_pc4, 32'd12);

        // 3: ack delayed three cycles
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3 addr held", imem_addr, 32'd12);
            check("t3 req held", {31'd0, imem_req}, 32'd1);
            check("t3 bubble", {31'd0, id_valid}, 32'd0);
        end
        imem_ack = 1'b1; imem_rdata = 32'h0123_4567;
        tick();
        check("t3 valid", {31'd0, id_valid}, 32'd1);
        check("t3 instr", id_instr, 32'h0123_4567);
        check("t3 addr16", imem_addr, 32'd16);

        // 4: ack while stalled parks the word
        stall = 1'b1; imem_rdata = 32'h8C09_0010;
        tick();
        imem_ack = 1'b0;
        check("t4 req in hold", {31'd0, imem_req}, 32'd0);
        check("t4 id held", id_instr, 32'h0123_4567);
        check("t4 valid held", {31'd0, id_valid}, 32'd1);
        tick();
        check("t4 still hold", {31'd0, imem_req}, 32'd0);
        stall = 1'b0;
        tick();
        check("t4 instr", id_instr, 32'h8C09_0010);
        check("t4 imm16", {16'd0, id_imm16}, 32'h0010);
        check("t4 pc4", id_pc4, 32'd20);
        check("t4 req", {31'd0, imem_req}, 32'd1);
        check("t4 addr", imem_addr, 32'd20);

        // 5: flush with a same-cycle ack, then again with stall
        flush = 1'b1; redirect_pc = 32'h40; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        flush = 1'b0; imem_ack = 1'b0;
        check("t5 valid", {31'd0, id_valid}, 32'd0);
        check("t5 addr", imem_addr, 32'h40);
        check("t5 instr not acked", id_instr, 32'h8C09_0010);
        tick();
        check("t5 no leak", id_instr, 32'h8C09_0010);
        imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
        tick();
        check("t5 refill", id_instr, 32'h1111_1111);
        flush = 1'b1; stall = 1'b1; redirect_pc = 32'h80; imem_rdata = 32'hCAFE_F00D;
        tick();
        flush = 1'b0; stall = 1'b0; imem_ack = 1'b0;
        check("t5s valid", {31'd0, id_valid}, 32'd0);
        check("t5s addr", imem_addr, 32'h80);
        check("t5s req", {31'd0, imem_req}, 32'd1);
        check("t5s instr", id_instr, 32'h1111_1111);
        tick();

        // mid-operation reset with a pending ack
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
        #1;
        check("rst req low", {31'd0, imem_req}, 32'd0);
        tick();
        check("rst addr", imem_addr, 32'd0);
        check("rst instr", id_instr, 32'd0);
        check("rst pc4", id_pc4, 32'd0);
        rst = 1'b1; imem_ack = 1'b0;
        tick(); tick();

        // 6: PC wrap from 32'hFFFF_FFFC
        rst2 = 1'b1;
        tick();
        check("t6 addr", imem_addr2, 32'hFFFF_FFFC);
        check("t6 req", {31'd0, imem_req2}, 32'd1);
        imem_ack2 = 1'b1; imem_rdata2 = 32'h2402_0001;
        tick();
        imem_ack2 = 1'b0;
        check("t6 valid", {31'd0, id_valid2}, 32'd1);
        check("t6 pc4 wrap", id_pc4_2, 32'd0);
        check("t6 addr wrap", imem_addr2, 32'd0);
        check("t6 instr", id_instr2, 32'h2402_0001);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
